stack_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared behavioural stack (DATA_W wide, clk/push/pop/data_in/data_out/full/empty interface).
- Each requester issues a push or pop command with a req/ack handshake.
- The arbiter serialises commands, drives single-cycle push/pop pulses into the stack, and captures popped data.
- Illegal operations (push when full, pop when empty) are rejected with an error flag and are never forwarded to the stack.

---
 rtl/stack_arbiter.sv | 140 ++++++++++++++
 tb/tb_stack_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter: two-requester round-robin arbiter that serialises push/pop
// commands onto a shared stack and returns popped data to the winner.
// Ports: clk, rst (sync, active high); per requester N in {0,1}:
//   reqN/opN/wdataN in (op 0=push, 1=pop), ackN/errN/rdataN out;
//   busy out; stack side: stk_push/stk_pop/stk_din out,
//   stk_dout/stk_full/stk_empty in.
module stack_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              op0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              op1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic              stk_full,
    input  logic              stk_empty
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              win_q, win_d;
    logic              op_q, op_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              sel;
    logic              sel_op;
    logic              issue;
    logic              resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            win_q    <= 1'b0;
            op_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // A lone requester wins outright; on contention the rr pointer decides.
    assign sel    = (req0 & req1) ? rr_q : req1;
    assign sel_op = sel ? op1 : op0;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        win_d    = win_q;
        op_d     = op_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    win_d   = sel;
                    op_d    = sel_op;
                    wdata_d = sel ? wdata1 : wdata0;
                    // Only this block touches the stack, so the flags
                    // seen here still hold when the strobe fires.
                    err_d   = sel_op ? stk_empty : stk_full;
                    state_d = err_d ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // stk_dout is valid the cycle after the pop edge.
                if (op_q) begin
                    if (win_q) begin
                        rdata1_d = stk_dout;
                    end else begin
                        rdata0_d = stk_dout;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                rr_d    = ~win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issue    = (state_q == ISSUE);
    assign resp     = (state_q == RESP);

    assign busy     = (state_q != IDLE);
    assign stk_push = issue & ~op_q;
    assign stk_pop  = issue & op_q;
    assign stk_din  = stk_push ? wdata_q : '0;

    assign ack0     = resp & ~win_q;
    assign ack1     = resp & win_q;
    assign err0     = ack0 & err_q;
    assign err1     = ack1 & err_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       rst, srst;
    logic       req0, op0, req1, op1;
    logic [3:0] wdata0, wdata1;
    logic       ack0, err0, ack1, err1, busy;
    logic [3:0] rdata0, rdata1;
    logic       stk_push, stk_pop, stk_full, stk_empty;
    logic [3:0] stk_din, stk_dout;

    int checks = 0;
    int failures = 0;
    int npush = 0;
    int npop = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .op1(op1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .busy(busy),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    // Behavioural 8-deep stack, reset independently of the arbiter.
    logic [3:0] smem [8];
    int         scnt = 0;
    logic [3:0] sdout = 4'h0;

    always @(posedge clk) begin
        if (srst) begin
            scnt <= 0;
        end else if (stk_push && scnt < 8) begin
            smem[scnt] <= stk_din;
            scnt <= scnt + 1;
        end else if (stk_pop && scnt > 0) begin
            sdout <= smem[scnt-1];
            scnt <= scnt - 1;
        end
    end
    assign stk_dout  = sdout;
    assign stk_full  = (scnt == 8);
    assign stk_empty = (scnt == 0);

    always @(negedge clk) begin
        if (stk_push) npush++;
        if (stk_pop) npop++;
        checks++;
        if (stk_push && stk_pop) begin
            failures++;
            $display("FAIL strobe_overlap actual=push&pop required=one");
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] outs();
        return {busy, stk_push, stk_pop, stk_din,
                ack0, err0, rdata0, ack1, err1, rdata1};
    endfunction

    task automatic do_reset();
        rst = 1; srst = 1;
        req0 = 0; op0 = 0; wdata0 = 0;
        req1 = 0; op1 = 0; wdata1 = 0;
        step();
        rst = 0; srst = 0;
    endtask

    // Issue one command from an idle arbiter; lat counts edges to ack.
    task automatic do_cmd(input bit id, input logic op, input logic [3:0] d,
                          output int lat, output logic e,
                          output logic [3:0] rd);
        bit got = 0;
        lat = 0; e = 0; rd = 0;
        if (id) begin
            req1 = 1; op1 = op; wdata1 = d;
        end else begin
            req0 = 1; op0 = op; wdata0 = d;
        end
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            lat++;
            if (id ? ack1 : ack0) begin
                got = 1;
                e = id ? err1 : err0;
                rd = id ? rdata1 : rdata0;
            end
        end
        req0 = 0; req1 = 0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL cmd_timeout id=%0d actual=none required=ack", id);
        end
        step();
    endtask

    typedef struct {
        logic       rst, srst, r0, o0;
        logic [3:0] w0;
        logic       r1, o1;
        logic [3:0] w1;
        logic       busy, push, pop;
        logic [3:0] din;
        logic       a0, e0, a1, e1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rs, logic sr, logic r0, logic o0,
                               logic [3:0] w0, logic r1, logic o1,
                               logic [3:0] w1, logic b, logic pu,
                               logic po, logic [3:0] di, logic a0,
                               logic e0, logic a1, logic e1);
        vec_t x;
        x.rst = rs; x.srst = sr; x.r0 = r0; x.o0 = o0; x.w0 = w0;
        x.r1 = r1; x.o1 = o1; x.w1 = w1; x.busy = b; x.push = pu;
        x.pop = po; x.din = di; x.a0 = a0; x.e0 = e0; x.a1 = a1; x.e1 = e1;
        return x;
    endfunction

    // Reference model: one command in flight, ack after 3 edges when
    // legal or 1 edge when rejected; stack held as a queue.
    logic       m_busy, m_win, m_op, m_err, m_rr;
    int         m_rem;
    logic [3:0] m_data, m_pend, m_rd0, m_rd1;
    logic [3:0] mq[$];

    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_rr = 0; m_rd0 = 0; m_rd1 = 0; m_rem = 0;
            m_win = 0; m_op = 0; m_err = 0; m_data = 0;
        end else if (m_busy) begin
            if (m_rem == 0) begin
                m_busy = 0;
                m_rr = !m_win;
            end else begin
                m_rem--;
                if (m_rem == 0 && m_op) begin
                    if (m_win) m_rd1 = m_pend;
                    else m_rd0 = m_pend;
                end
            end
        end else if (req0 || req1) begin
            m_win = (req0 && req1) ? m_rr : req1;
            m_op = m_win ? op1 : op0;
            m_data = m_win ? wdata1 : wdata0;
            m_err = m_op ? (mq.size() == 0) : (mq.size() == 8);
            if (!m_err) begin
                if (m_op) m_pend = mq.pop_back();
                else mq.push_back(m_data);
            end
            m_busy = 1;
            m_rem = m_err ? 0 : 2;
        end
    endtask

    function automatic logic [18:0] model_outs();
        logic iss, ack, pu, po;
        iss = m_busy && m_rem == 2;
        ack = m_busy && m_rem == 0;
        pu = iss && !m_op;
        po = iss && m_op;
        return {m_busy, pu, po, pu ? m_data : 4'h0,
                ack && !m_win, ack && !m_win && m_err, m_rd0,
                ack && m_win, ack && m_win && m_err, m_rd1};
    endfunction

    initial begin
        int         lat;
        logic       e;
        logic [3:0] rd;
        int         p;
        int         grants[$];
        int         guard;

        do_reset();
        chk("reset_outs", 32'(outs()), 32'h0);

        // rst srst r0 o0 w0 r1 o1 w1 | busy push pop din a0 e0 a1 e1
        tbl.push_back(v(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,3,0,0,0, 1,1,0,3,0,0,0,0));
        tbl.push_back(v(0,0,1,0,3,0,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,3,0,0,0, 1,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,5,1,1,0, 1,0,0,0,0,0,1,1));
        tbl.push_back(v(0,0,1,0,5,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,5,0,0,0, 1,1,0,5,0,0,0,0));
        tbl.push_back(v(0,0,1,0,5,0,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,5,0,0,0, 1,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,7,0,0,0, 1,1,0,7,0,0,0,0));
        tbl.push_back(v(1,0,1,0,7,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,7,1,0,9, 1,1,0,7,0,0,0,0));
        tbl.push_back(v(0,0,1,0,7,1,0,9, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,7,1,0,9, 1,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1,0,9, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1,0,9, 1,1,0,9,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1,0,9, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1,0,9, 1,0,0,0,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; srst = tbl[i].srst;
            req0 = tbl[i].r0; op0 = tbl[i].o0; wdata0 = tbl[i].w0;
            req1 = tbl[i].r1; op1 = tbl[i].o1; wdata1 = tbl[i].w1;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].busy, tbl[i].push, tbl[i].pop, tbl[i].din,
                     tbl[i].a0, tbl[i].e0, 4'h0,
                     tbl[i].a1, tbl[i].e1, 4'h0}));
        end
        rst = 0; srst = 0;
        chk("tbl_depth", 32'(scnt), 32'd4);
        chk("tbl_top", 32'(smem[3]), 32'h9);

        // LIFO fill and drain, then pop on empty.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            do_cmd(0, 0, 4'(i), lat, e, rd);
            chk("push_lat", 32'(lat), 32'd3);
            chk("push_err", 32'(e), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            do_cmd(1, 1, 4'h0, lat, e, rd);
            chk("pop_lat", 32'(lat), 32'd3);
            chk("pop_err", 32'(e), 32'd0);
            chk("pop_data", 32'(rd), 32'(8 - i));
        end
        p = npop;
        do_cmd(1, 1, 4'h0, lat, e, rd);
        chk("epop_lat", 32'(lat), 32'd1);
        chk("epop_err", 32'(e), 32'd1);
        chk("epop_rdata", 32'(rdata1), 32'h1);
        chk("epop_nostrobe", 32'(npop - p), 32'd0);

        // Push on full.
        for (int i = 0; i < 8; i++) begin
            do_cmd(0, 0, 4'(i + 1), lat, e, rd);
        end
        p = npush;
        do_cmd(0, 0, 4'hA, lat, e, rd);
        chk("fpush_lat", 32'(lat), 32'd1);
        chk("fpush_err", 32'(e), 32'd1);
        chk("fpush_nostrobe", 32'(npush - p), 32'd0);
        chk("fpush_full", 32'(stk_full), 32'd1);

        // Both requesters hold push requests: grants alternate.
        do_reset();
        req0 = 1; op0 = 0; wdata0 = 4'h1;
        req1 = 1; op1 = 0; wdata1 = 4'h2;
        guard = 0;
        while (grants.size() < 4 && guard < 40) begin
            step();
            guard++;
            if (ack0) grants.push_back(0);
            if (ack1) grants.push_back(1);
        end
        req0 = 0; req1 = 0;
        step();
        chk("alt_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk("alt_grant", 32'(grants[i]), 32'(i % 2));
            chk("alt_stack", 32'(smem[i]), 32'(i % 2 + 1));
        end
        chk("alt_depth", 32'(scnt), 32'd4);

        // Randomized traffic against the reference model.
        rst = 1; srst = 1;
        req0 = 0; req1 = 0;
        model_edge();
        step();
        mq.delete();
        rst = 0; srst = 0;
        for (int c = 0; c < 3000; c++) begin
            model_edge();
            step();
            chk("rand", 32'(outs()), 32'(model_outs()));
            if (ack0) begin
                req0 = 1'($urandom_range(0, 1));
                op0 = 1'($urandom_range(0, 1));
                wdata0 = 4'($urandom);
            end else if (!req0 && $urandom_range(0, 9) < 3) begin
                req0 = 1;
                op0 = 1'($urandom_range(0, 1));
                wdata0 = 4'($urandom);
            end
            if (ack1) begin
                req1 = 1'($urandom_range(0, 1));
                op1 = 1'($urandom_range(0, 1));
                wdata1 = 4'($urandom);
            end else if (!req1 && $urandom_range(0, 9) < 3) begin
                req1 = 1;
                op1 = 1'($urandom_range(0, 1));
                wdata1 = 4'($urandom);
            end
        end
        chk("rand_depth", 32'(scnt), 32'(mq.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
